hazard_forward_unit: RTL and testbench

- Parametrised hazard-detection and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Replaces the ad-hoc ForwardA/B/D/E and stall equations in the top level.
- Keeps its own registered copy of the in-flight destination tags for EX, MEM and WB, so it only needs the ID-stage instruction fields.
- Adds three things the current design lacks: an N-operand generalisation, a multi-cycle load latency with a whole-pipe hold, and branch-in-ID operand hazards.

---
 rtl/hazard_forward_unit.sv | 183 ++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_forward_unit #(
    parameter int NUM_SRC = 2,
    parameter int RA_W    = 5,
    parameter int MEM_LAT = 1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    id_valid,
    input  logic [NUM_SRC*RA_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]      id_src_used,
    input  logic [RA_W-1:0]         id_dst_addr,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    id_is_branch,
    input  logic                    br_taken,
    output logic                    pc_en,
    output logic                    ifid_en,
    output logic                    ifid_flush,
    output logic                    idex_bubble,
    output logic                    pipe_hold,
    output logic [NUM_SRC*2-1:0]    fwd_ex_sel,
    output logic [NUM_SRC*2-1:0]    fwd_id_sel,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             hold_cycles
);

    localparam logic [3:0] HOLD_INIT = 4'(MEM_LAT - 1);

    logic                    ex_wr_q, ex_wr_d;
    logic                    ex_ld_q, ex_ld_d;
    logic [RA_W-1:0]         ex_dst_q, ex_dst_d;
    logic [NUM_SRC*RA_W-1:0] ex_src_q, ex_src_d;
    logic [NUM_SRC-1:0]      ex_used_q, ex_used_d;
    logic                    mem_wr_q, mem_wr_d;
    logic                    mem_ld_q, mem_ld_d;
    logic [RA_W-1:0]         mem_dst_q, mem_dst_d;
    logic                    wb_wr_q, wb_wr_d;
    logic [RA_W-1:0]         wb_dst_q, wb_dst_d;
    logic [3:0]              hold_cnt_q, hold_cnt_d;

    logic [NUM_SRC-1:0] id_m_ex, id_m_mem, id_m_wb;
    logic [NUM_SRC-1:0] ex_m_mem, ex_m_wb;
    logic               load_use, br_stall, stall;

    // Register 0 never matches; an unread operand never matches.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [RA_W-1:0] id_s;
        logic [RA_W-1:0] ex_s;
        logic            id_nz;
        logic            ex_nz;

        assign id_s  = id_src_addr[k*RA_W +: RA_W];
        assign ex_s  = ex_src_q[k*RA_W +: RA_W];
        assign id_nz = id_src_used[k] && (id_s != '0);
        assign ex_nz = ex_used_q[k] && (ex_s != '0);

        assign id_m_ex[k]  = id_nz && ex_wr_q && (id_s == ex_dst_q);
        assign id_m_mem[k] = id_nz && mem_wr_q && (id_s == mem_dst_q);
        assign id_m_wb[k]  = id_nz && wb_wr_q && (id_s == wb_dst_q);
        assign ex_m_mem[k] = ex_nz && mem_wr_q && (ex_s == mem_dst_q);
        assign ex_m_wb[k]  = ex_nz && wb_wr_q && (ex_s == wb_dst_q);

        assign fwd_ex_sel[2*k +: 2] =
            (ex_m_mem[k] && !mem_ld_q) ? 2'd2 :
            ex_m_wb[k]                 ? 2'd1 : 2'd0;
        assign fwd_id_sel[2*k +: 2] =
            (id_m_mem[k] && !mem_ld_q) ? 2'd1 :
            id_m_wb[k]                 ? 2'd2 : 2'd0;
    end

    assign load_use = id_valid && ex_ld_q && (|id_m_ex);
    assign br_stall = id_is_branch &&
                      ((|id_m_ex) || (mem_ld_q && (|id_m_mem)));
    assign pipe_hold = (hold_cnt_q != 4'd0);
    assign stall     = (load_use || br_stall) && !pipe_hold;

    assign pc_en       = !(stall || pipe_hold);
    assign ifid_en     = !(stall || pipe_hold);
    assign idex_bubble = stall;
    assign ifid_flush  = br_taken && !stall && !pipe_hold;

    // Advance destination tags: hold freezes EX/MEM, stall bubbles EX.
    always_comb begin
        ex_wr_d   = ex_wr_q;
        ex_ld_d   = ex_ld_q;
        ex_dst_d  = ex_dst_q;
        ex_src_d  = ex_src_q;
        ex_used_d = ex_used_q;
        mem_wr_d  = mem_wr_q;
        mem_ld_d  = mem_ld_q;
        mem_dst_d = mem_dst_q;
        wb_wr_d   = wb_wr_q;
        wb_dst_d  = wb_dst_q;
        if (pipe_hold) begin
            wb_wr_d = 1'b0;
        end else begin
            mem_wr_d  = ex_wr_q;
            mem_ld_d  = ex_ld_q;
            mem_dst_d = ex_dst_q;
            wb_wr_d   = mem_wr_q;
            wb_dst_d  = mem_dst_q;
            if (stall) begin
                ex_wr_d   = 1'b0;
                ex_ld_d   = 1'b0;
                ex_used_d = '0;
            end else begin
                ex_wr_d   = id_valid && id_reg_write;
                ex_ld_d   = id_valid && id_mem_read;
                ex_used_d = id_valid ? id_src_used : '0;
                ex_src_d  = id_src_addr;
                ex_dst_d  = id_dst_addr;
            end
        end
    end

    // Load entering MEM arms the hold counter for the extra latency.
    always_comb begin
        hold_cnt_d = 4'd0;
        if (pipe_hold) begin
            hold_cnt_d = hold_cnt_q - 4'd1;
        end else if (ex_ld_q) begin
            hold_cnt_d = HOLD_INIT;
        end
    end

    // Tracking registers and hold counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_wr_q    <= 1'b0;
            ex_ld_q    <= 1'b0;
            ex_dst_q   <= '0;
            ex_src_q   <= '0;
            ex_used_q  <= '0;
            mem_wr_q   <= 1'b0;
            mem_ld_q   <= 1'b0;
            mem_dst_q  <= '0;
            wb_wr_q    <= 1'b0;
            wb_dst_q   <= '0;
            hold_cnt_q <= 4'd0;
        end else begin
            ex_wr_q    <= ex_wr_d;
            ex_ld_q    <= ex_ld_d;
            ex_dst_q   <= ex_dst_d;
            ex_src_q   <= ex_src_d;
            ex_used_q  <= ex_used_d;
            mem_wr_q   <= mem_wr_d;
            mem_ld_q   <= mem_ld_d;
            mem_dst_q  <= mem_dst_d;
            wb_wr_q    <= wb_wr_d;
            wb_dst_q   <= wb_dst_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] hold_cycles_q;

    // Free-running stall and hold cycle counters, wrapping at 2^32.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cycles_q <= '0;
            hold_cycles_q  <= '0;
        end else begin
            if (stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (pipe_hold) begin
                hold_cycles_q <= hold_cycles_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign hold_cycles  = hold_cycles_q;
`else
    assign stall_cycles = '0;
    assign hold_cycles  = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for hazard_forward_unit.
// MEM_LAT = 3; outputs checked on the falling edge.
module tb_hazard_forward_unit;

  localparam int NUM_SRC = 2;
  localparam int RA_W    = 5;
  localparam int MEM_LAT = 3;

  typedef struct packed {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] u;
    logic [4:0] d;
    logic       wr;
    logic       ld;
    logic       br;
    logic       tk;
  } ins_t;

  typedef struct packed {
    logic [12:0] ctl;
    logic [31:0] st;
    logic [31:0] ho;
  } exp_t;

  logic                    Clk;
  logic                    Rst_n;
  logic                    id_valid;
  logic [NUM_SRC*RA_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]      id_src_used;
  logic [RA_W-1:0]         id_dst_addr;
  logic                    id_reg_write;
  logic                    id_mem_read;
  logic                    id_is_branch;
  logic                    br_taken;
  logic                    pc_en;
  logic                    ifid_en;
  logic                    ifid_flush;
  logic                    idex_bubble;
  logic                    pipe_hold;
  logic [NUM_SRC*2-1:0]    fwd_ex_sel;
  logic [NUM_SRC*2-1:0]    fwd_id_sel;
  logic [31:0]             stall_cycles;
  logic [31:0]             hold_cycles;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests;
  int    fails;
  int    n_step;
  logic [31:0] exp_st;
  logic [31:0] exp_ho;
  exp_t  mon_e;
  exp_t  mon_a;
  string mon_n;

  hazard_forward_unit #(
    .NUM_SRC(NUM_SRC),
    .RA_W   (RA_W),
    .MEM_LAT(MEM_LAT)
  ) u_dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .id_valid    (id_valid),
    .id_src_addr (id_src_addr),
    .id_src_used (id_src_used),
    .id_dst_addr (id_dst_addr),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .id_is_branch(id_is_branch),
    .br_taken    (br_taken),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pipe_hold   (pipe_hold),
    .fwd_ex_sel  (fwd_ex_sel),
    .fwd_id_sel  (fwd_id_sel),
    .stall_cycles(stall_cycles),
    .hold_cycles (hold_cycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic ins_t mk_i(
    input logic v, input logic [4:0] s0,
    input logic [4:0] s1, input logic [1:0] u,
    input logic [4:0] d, input logic wr,
    input logic ld, input logic br,
    input logic tk);
    ins_t r;
    r.v  = v;
    r.s0 = s0;
    r.s1 = s1;
    r.u  = u;
    r.d  = d;
    r.wr = wr;
    r.ld = ld;
    r.br = br;
    r.tk = tk;
    return r;
  endfunction

  function automatic logic [12:0] mk_e(
    input logic pc, input logic bub,
    input logic fl, input logic hd,
    input logic [3:0] fex,
    input logic [3:0] fid);
    return {pc, pc, fl, bub, hd, fex, fid};
  endfunction

  task automatic step(input string nm,
                      input ins_t i,
                      input logic [12:0] c,
                      input logic rst);
    exp_t e;
    @(posedge Clk);
    #1;
    if (!rst) Rst_n = 1'b1;
    id_valid     = i.v;
    id_src_addr  = {i.s1, i.s0};
    id_src_used  = i.u;
    id_dst_addr  = i.d;
    id_reg_write = i.wr;
    id_mem_read  = i.ld;
    id_is_branch = i.br;
    br_taken     = i.tk;
    e.ctl = c;
`ifdef HAZ_PERF_CNT_EN
    e.st = rst ? 32'd0 : exp_st;
    e.ho = rst ? 32'd0 : exp_ho;
`else
    e.st = 32'd0;
    e.ho = 32'd0;
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    n_step = n_step + 1;
    if (rst) begin
      #1;
      Rst_n  = 1'b0;
      exp_st = 32'd0;
      exp_ho = 32'd0;
    end else begin
      exp_st = exp_st + 32'(c[9]);
      exp_ho = exp_ho + 32'(c[8]);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a.ctl = {pc_en, ifid_en, ifid_flush,
                   idex_bubble, pipe_hold,
                   fwd_ex_sel, fwd_id_sel};
      mon_a.st  = stall_cycles;
      mon_a.ho  = hold_cycles;
      tests = tests + 1;
      if (mon_a !== mon_e) begin
        fails = fails + 1;
        $display("FAIL %s: got ctl=%b st=%0d ho=%0d",
                 mon_n, mon_a.ctl, mon_a.st, mon_a.ho);
        $display("  want ctl=%b st=%0d ho=%0d",
                 mon_e.ctl, mon_e.st, mon_e.ho);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ins_t        nop;
    ins_t        add_r5;
    ins_t        beq3;
    ins_t        tka;
    logic [12:0] z;

    tests        = 0;
    fails        = 0;
    n_step       = 0;
    exp_st       = 32'd0;
    exp_ho       = 32'd0;
    Rst_n        = 1'b0;
    id_valid     = 1'b0;
    id_src_addr  = '0;
    id_src_used  = '0;
    id_dst_addr  = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    id_is_branch = 1'b0;
    br_taken     = 1'b0;

    nop    = mk_i(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    add_r5 = mk_i(1, 2, 1, 2'b11, 5, 1, 0, 0, 0);
    beq3   = mk_i(1, 3, 0, 2'b11, 0, 0, 0, 1, 1);
    tka    = mk_i(1, 1, 2, 2'b11, 8, 1, 0, 0, 1);
    z      = mk_e(1, 0, 0, 0, 4'b0000, 4'b0000);

    step("reset", nop, z, 1'b1);

    step("g_lw",
         mk_i(1, 1, 0, 2'b01, 9, 1, 1, 0, 0),
         z, 1'b0);
    step("g_nop", nop, z, 1'b0);
    step("g_rst_mid_hold",
         mk_i(1, 9, 0, 2'b01, 0, 0, 0, 1, 0),
         z, 1'b1);
    step("g_after_rst", nop, z, 1'b0);

    step("a_add",
         mk_i(1, 1, 2, 2'b11, 3, 1, 0, 0, 0),
         z, 1'b0);
    step("a_sub",
         mk_i(1, 3, 3, 2'b11, 4, 1, 0, 0, 0),
         z, 1'b0);
    step("a_ex_mem_fwd",
         mk_i(1, 3, 0, 2'b11, 5, 1, 0, 0, 0),
         mk_e(1, 0, 0, 0, 4'b1010, 4'b0001), 1'b0);
    step("a_ex_wb_fwd", nop,
         mk_e(1, 0, 0, 0, 4'b0001, 4'b0000), 1'b0);
    step("a_drain1", nop, z, 1'b0);
    step("a_drain2", nop, z, 1'b0);

    step("b_lw",
         mk_i(1, 1, 0, 2'b01, 2, 1, 1, 0, 0),
         z, 1'b0);
    step("b_load_use", add_r5,
         mk_e(0, 1, 0, 0, 4'b0000, 4'b0000), 1'b0);
    step("b_hold1", add_r5,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("b_hold2", add_r5,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("b_issue", add_r5, z, 1'b0);
    step("b_ex_wb_fwd", nop,
         mk_e(1, 0, 0, 0, 4'b0001, 4'b0000), 1'b0);
    step("b_drain1", nop, z, 1'b0);
    step("b_drain2", nop, z, 1'b0);

    step("c_add",
         mk_i(1, 1, 2, 2'b11, 3, 1, 0, 0, 0),
         z, 1'b0);
    step("c_br_stall", beq3,
         mk_e(0, 1, 0, 0, 4'b0000, 4'b0000), 1'b0);
    step("c_br_fwd_mem", beq3,
         mk_e(1, 0, 1, 0, 4'b0000, 4'b0001), 1'b0);
    step("c_ex_wb", nop,
         mk_e(1, 0, 0, 0, 4'b0001, 4'b0000), 1'b0);
    step("c_drain1", nop, z, 1'b0);
    step("c_drain2", nop, z, 1'b0);

    step("d_lw",
         mk_i(1, 1, 0, 2'b01, 3, 1, 1, 0, 0),
         z, 1'b0);
    step("d_br_stall_ex", beq3,
         mk_e(0, 1, 0, 0, 4'b0000, 4'b0000), 1'b0);
    step("d_hold1", beq3,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("d_hold2", beq3,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("d_br_stall_mem", beq3,
         mk_e(0, 1, 0, 0, 4'b0000, 4'b0000), 1'b0);
    step("d_br_fwd_wb", beq3,
         mk_e(1, 0, 1, 0, 4'b0000, 4'b0010), 1'b0);
    step("d_drain1", nop, z, 1'b0);
    step("d_drain2", nop, z, 1'b0);

    step("e_add_r0",
         mk_i(1, 1, 2, 2'b11, 0, 1, 0, 0, 0),
         z, 1'b0);
    step("e_br_r0",
         mk_i(1, 0, 0, 2'b11, 0, 0, 0, 1, 0),
         z, 1'b0);
    step("e_rd_r0",
         mk_i(1, 0, 0, 2'b11, 4, 1, 0, 0, 0),
         z, 1'b0);
    step("e_nop", nop, z, 1'b0);
    step("e_lw_r0",
         mk_i(1, 1, 0, 2'b01, 0, 1, 1, 0, 0),
         z, 1'b0);
    step("e_use_r0",
         mk_i(1, 0, 0, 2'b11, 6, 1, 0, 0, 0),
         z, 1'b0);
    step("e_hold1", nop,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("e_hold2", nop,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("e_resume", nop, z, 1'b0);
    step("e_drain1", nop, z, 1'b0);
    step("e_drain2", nop, z, 1'b0);

    step("f_lw",
         mk_i(1, 1, 0, 2'b01, 7, 1, 1, 0, 0),
         z, 1'b0);
    step("f_nop", nop, z, 1'b0);
    step("f_hold_tk1", tka,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("f_hold_tk2", tka,
         mk_e(0, 0, 0, 1, 4'b0000, 4'b0000), 1'b0);
    step("f_flush", tka,
         mk_e(1, 0, 1, 0, 4'b0000, 4'b0000), 1'b0);
    step("f_drain1", nop, z, 1'b0);
    step("f_drain2", nop, z, 1'b0);
    step("f_drain3", nop, z, 1'b0);

    repeat (2) @(posedge Clk);
    #1;
    if (tests != n_step) begin
      fails = fails + 1;
      $display("FAIL count: %0d checks, %0d steps",
               tests, n_step);
    end
    if (pipe_hold !== 1'b0 || pc_en !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL idle: hold=%b pc_en=%b",
               pipe_hold, pc_en);
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    if (fails != 0) $display("FAIL");
    else $display("PASS");
    $finish;
  end

endmodule
